// File: rtl/shift_right_seq.sv
// shift_right_seq -- multi-cycle right shifter, one bit position per clock.
//
// An operand is loaded on an accepted start. It is then shifted right by one
// bit on each clock, shamt times in total, and done is pulsed for one cycle
// with the result.
//
// Optional feature: define SHIFT_ROT_EN to compile the rotate-right path for
// op 2'b10. When SHIFT_ROT_EN is undefined, op 2'b10 behaves as SRL.
//
// Ports:
//   clk        in   1        clock, rising edge
//   rst_n      in   1        asynchronous active-low reset
//   start      in   1        request; sampled only in IDLE
//   op         in   2        00 SRL, 01 SRA, 10 ROR, 11 reserved (SRL)
//   data_in    in   WIDTH    operand, latched on accept
//   shamt      in   SHAMT_W  shift amount 0..WIDTH-1, latched on accept
//   busy       out  1        high in SHIFT and DONE
//   done       out  1        one-cycle result-valid pulse
//   data_out   out  WIDTH    working/result register
//   carry_out  out  1        last bit shifted out of bit 0
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start; data_out/carry_out hold the last result
// SHIFT | one bit position per clock until the latched count runs out
// DONE  | result valid, done=1 for this single cycle

module shift_right_seq #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   data_out,
  output logic               carry_out
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_t;

  state_t             state, state_nxt;
  logic [1:0]         op_q;
  logic [SHAMT_W-1:0] count;
  logic               fill;
  logic               accept;

  assign accept = (state == S_IDLE) && start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = (shamt == '0) ? S_DONE : S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (count == SHAMT_W'(1)) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Bit entering at the MSB on each shift step.
  always_comb begin
    fill = 1'b0;
    case (op_q)
      2'b01:   fill = data_out[WIDTH-1];
`ifdef SHIFT_ROT_EN
      2'b10:   fill = data_out[0];
`endif
      default: fill = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out  <= '0;
      carry_out <= 1'b0;
      op_q      <= 2'b00;
      count     <= '0;
    end else if (accept) begin
      data_out  <= data_in;
      carry_out <= 1'b0;
      op_q      <= op;
      count     <= shamt;
    end else if (state == S_SHIFT) begin
      data_out  <= {fill, data_out[WIDTH-1:1]};
      carry_out <= data_out[0];
      count     <= count - SHAMT_W'(1);
    end
  end

  // Decoded straight from the state register, so there is no path from inputs.
  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_shift_right_seq.sv
module tb_shift_right_seq;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] data_in;
  logic [2:0]   shamt;
  logic         busy;
  logic         done;
  logic [W-1:0] data_out;
  logic         carry_out;

  shift_right_seq #(.WIDTH(W), .SHAMT_W(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (op),
    .data_in   (data_in),
    .shamt     (shamt),
    .busy      (busy),
    .done      (done),
    .data_out  (data_out),
    .carry_out (carry_out)
  );

  typedef struct {
    logic [W-1:0] data;
    logic         carry;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: whole-operand arithmetic, no per-step iteration.
  function automatic logic [W-1:0] model_data(input logic [1:0] o, input logic [W-1:0] d, input int n);
    logic signed [W-1:0] s;
    logic [2*W-1:0]      dd;
    s  = d;
    dd = {d, d} >> n;
    case (o)
      2'b01: return W'(s >>> n);
`ifdef SHIFT_ROT_EN
      2'b10: return dd[W-1:0];
`endif
      default: return d >> n;
    endcase
  endfunction

  function automatic logic model_carry(input logic [W-1:0] d, input int n);
    if (n == 0) return 1'b0;
    return d[n-1];
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result_data",  data_out, e.data);
        chk("result_carry", carry_out, e.carry);
        chk("done_cycle",   cyc, e.cyc);
        chk("busy_in_done", busy, 1'b1);
      end
    end
  end

  // Called at a negedge with the FSM in IDLE; returns at a negedge in IDLE.
  task automatic do_op(input logic [1:0] o, input logic [W-1:0] d, input int n, input bit disturb);
    exp_t e;
    int   guard;
    e.data  = model_data(o, d, n);
    e.carry = model_carry(d, n);
    e.cyc   = cyc + 1 + n;
    sb.push_back(e);
    start   = 1'b1;
    op      = o;
    data_in = d;
    shamt   = 3'(n);
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    while (done !== 1'b1 && guard < 2 * W) begin
      chk("busy_while_shifting", busy, 1'b1);
      if (disturb) begin
        start   = 1'b1;
        op      = 2'($urandom);
        data_in = W'($urandom);
        shamt   = 3'($urandom);
      end
      @(negedge clk);
      guard++;
    end
    if (done !== 1'b1) chk("done_timeout", 32'd0, 32'd1);
    start = disturb;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_done", busy, 1'b0);
    chk("done_single_cycle", done, 1'b0);
    chk("hold_data_idle", data_out, e.data);
    chk("hold_carry_idle", carry_out, e.carry);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b1;
    start   = 1'b0;
    op      = 2'b00;
    data_in = '0;
    shamt   = '0;
    #1 rst_n = 1'b0;
    #2;
    chk("reset_data",  data_out, 8'h00);
    chk("reset_carry", carry_out, 1'b0);
    chk("reset_busy",  busy, 1'b0);
    chk("reset_done",  done, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    do_op(2'b00, 8'hB4, 3, 1'b0);
    do_op(2'b01, 8'h96, 2, 1'b0);
    do_op(2'b11, 8'h96, 2, 1'b0);
    do_op(2'b10, 8'h81, 1, 1'b0);
    do_op(2'b10, 8'hB4, 7, 1'b0);
    do_op(2'b00, 8'h5A, 0, 1'b0);
    do_op(2'b00, 8'hFF, 7, 1'b1);

    // Abort an SRL 0xFF after two shifts with an asynchronous reset.
    start   = 1'b1;
    op      = 2'b00;
    data_in = 8'hFF;
    shamt   = 3'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_data",  data_out, 8'h00);
    chk("async_reset_carry", carry_out, 1'b0);
    chk("async_reset_busy",  busy, 1'b0);
    chk("async_reset_done",  done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_op(2'b00, 8'h80, 7, 1'b0);

    for (int i = 0; i < 40; i++) begin
      do_op(2'($urandom), W'($urandom), int'($urandom_range(0, W - 1)), bit'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
